// File: rtl/spi_sram_port.sv
// Purpose : serial SRAM master that turns one-word read/write requests into SPI mode-0 transactions.
// Latency : busy for 2*B+1 cycles, where B = 8 + ADDR_BITS + 8*DATA_WIDTH_BYTES bits (+8 for a fast read).
// Backpr. : no queueing. A start is honoured only in IDLE. Starts that arrive while busy are dropped.
//
// Targets a 23LC512-class part in byte-sequential mode (READ 0x03, WRITE 0x02).
// spi_clk_out runs at clk/2. Each bit is phase A (sclk low, new mosi bit) followed by
// phase B (sclk high). spi_miso is sampled on the clk edge that ends phase B.
//
// Optional feature macro: SPI_SRAM_FAST_READ_EN
//   defined   : reads use opcode 0x0B, followed by one 8-bit DUMMY byte (mosi=0, miso ignored).
//   undefined : reads use opcode 0x03 and have no dummy byte.
//
// Ports:
//   clk, rst_n          : clock; synchronous active-low reset.
//   addr_in, data_in    : request address and write data, captured when a start is accepted.
//   start_read/_write   : one-cycle request pulses. The write wins if both are high.
//   data_out            : word from the last completed read. Updates on entry to END.
//   busy                : registered; high from the cycle after acceptance through END.
//   spi_select          : active-low chip select.
//   spi_clk_out         : SPI clock; idles low.
//   spi_mosi            : serial data to the SRAM.
//   spi_miso            : serial data from the SRAM.
module spi_sram_port #(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_BITS-1:0]          addr_in,
    input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
    input  logic                          start_read,
    input  logic                          start_write,
    output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
    output logic                          busy,
    output logic                          spi_select,
    output logic                          spi_clk_out,
    output logic                          spi_mosi,
    input  logic                          spi_miso
);

    localparam int DW = 8 * DATA_WIDTH_BYTES;

`ifdef SPI_SRAM_FAST_READ_EN
    localparam int         DUMMY_BITS = 8;
    localparam logic [7:0] OP_READ    = 8'h0B;
`else
    localparam int         DUMMY_BITS = 0;
    localparam logic [7:0] OP_READ    = 8'h03;
`endif
    localparam logic [7:0] OP_WRITE   = 8'h02;

    // The outgoing bit stream is preloaded in one register and shifted out MSB first.
    // Layout: opcode | address | data (writes), or opcode | address | zeros (reads).
    // Any dummy byte and all read-data bits are zeros, so mosi is low in those phases.
    localparam int TXW = 8 + ADDR_BITS + DUMMY_BITS + DW;

    // The per-state bit counter holds (bits remaining - 1). The largest field is 32 bits.
    localparam int             CW        = 5;
    localparam logic [CW-1:0]  CNT_BYTE  = CW'(7);
    localparam logic [CW-1:0]  CNT_ADDR  = CW'(ADDR_BITS - 1);
    localparam logic [CW-1:0]  CNT_DATA  = CW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef SPI_SRAM_FAST_READ_EN
        S_DUMMY,
`endif
        S_DATA,
        S_END
    } state_t;

    // The SPI byte order is lowest byte first; each byte is sent MSB first.
    // A byte swap maps the word onto an MSB-first stream, and is its own inverse.
    // The same swap therefore serves the transmit and receive directions.
    function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
            r[8*i +: 8] = v[8*(DATA_WIDTH_BYTES-1-i) +: 8];
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic             phase_q, phase_d;       // 0: phase A (sclk low), 1: phase B (sclk high)
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TXW-1:0]   tx_q, tx_d;
    logic [DW-1:0]    rx_q, rx_d;
    logic             is_wr_q, is_wr_d;
    logic [DW-1:0]    data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             sel_q, sel_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [TXW-1:0]   tx_load;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        is_wr_d    = is_wr_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        sel_d      = sel_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        tx_load    = '0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                sel_d  = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start_write || start_read) begin
                    tx_load[TXW-1 -: 8]         = start_write ? OP_WRITE : OP_READ;
                    tx_load[TXW-9 -: ADDR_BITS] = addr_in;
                    if (start_write) begin
                        tx_load[TXW-9-ADDR_BITS -: DW] = byte_swap(data_in);
                    end
                    tx_d    = tx_load;
                    is_wr_d = start_write;
                    state_d = S_CMD;
                    phase_d = 1'b0;
                    cnt_d   = CNT_BYTE;
                    // The first phase A starts in the very next cycle.
                    // Its mosi bit must therefore be loaded now.
                    busy_d  = 1'b1;
                    sel_d   = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_load[TXW-1];
                end
            end

            S_END: begin
                // One deselected cycle guarantees a select-high gap between transactions.
                state_d = S_IDLE;
                busy_d  = 1'b0;
                sel_d   = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end

            default: begin
                // These are the bit-serial states: CMD, ADDR, optional DUMMY, and DATA.
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    // This edge ends phase B. It is the miso sample point and the bit boundary.
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    tx_d    = tx_q << 1;
                    if (state_q == S_DATA && !is_wr_q) begin
                        rx_d = {rx_q[DW-2:0], spi_miso};
                    end
                    mosi_d = tx_d[TXW-1];
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        case (state_q)
                            S_CMD: begin
                                state_d = S_ADDR;
                                cnt_d   = CNT_ADDR;
                            end
                            S_ADDR: begin
`ifdef SPI_SRAM_FAST_READ_EN
                                if (!is_wr_q) begin
                                    state_d = S_DUMMY;
                                    cnt_d   = CNT_BYTE;
                                end else
`endif
                                begin
                                    state_d = S_DATA;
                                    cnt_d   = CNT_DATA;
                                end
                            end
`ifdef SPI_SRAM_FAST_READ_EN
                            S_DUMMY: begin
                                state_d = S_DATA;
                                cnt_d   = CNT_DATA;
                            end
`endif
                            default: begin
                                // The last data bit is done; deselect and go to END.
                                state_d = S_END;
                                sel_d   = 1'b1;
                                mosi_d  = 1'b0;
                                // data_out takes the whole word in one step.
                                // It includes the bit sampled on this same edge.
                                if (!is_wr_q) begin
                                    data_out_d = byte_swap(rx_d);
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            is_wr_q    <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            sel_q      <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            is_wr_q    <= is_wr_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            sel_q      <= sel_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign data_out    = data_out_q;
    assign busy        = busy_q;
    assign spi_select  = sel_q;
    assign spi_clk_out = sclk_q;
    assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_sram_port.sv
// Purpose : randomized scoreboard bench for spi_sram_port, with a behavioural serial-SRAM slave.
// Latency : the expected result of each request is queued at issue time and checked when busy falls.
// Backpr. : each request is issued only after busy has been observed low.
module tb_spi_sram_port;

    localparam int AB    = 16;
    localparam int DWB   = 2;
    localparam int DW    = 8 * DWB;
    localparam int MEMSZ = 1 << AB;
`ifdef SPI_SRAM_FAST_READ_EN
    localparam int         RD_EXTRA = 8;
    localparam logic [7:0] OP_RD    = 8'h0B;
`else
    localparam int         RD_EXTRA = 0;
    localparam logic [7:0] OP_RD    = 8'h03;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AB-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic          start_read = 1'b0;
    logic          start_write = 1'b0;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          spi_select;
    logic          spi_clk_out;
    logic          spi_mosi;
    logic          spi_miso = 1'b0;

    always #5 clk = ~clk;

    spi_sram_port #(.DATA_WIDTH_BYTES(DWB), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .data_in(data_in),
        .start_read(start_read), .start_write(start_write), .data_out(data_out),
        .busy(busy), .spi_select(spi_select), .spi_clk_out(spi_clk_out),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    typedef struct {
        int            nbits;
        logic [127:0]  stream;
        logic [DW-1:0] dout;
        int            busy_len;
        bit            is_abort;
        int            exp_gap;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [7:0]    ref_mem  [MEMSZ];
    logic [7:0]    sram_mem [MEMSZ];
    logic [DW-1:0] last_read = '0;
    bit            gap_known = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // This is a serial SRAM slave, written at the protocol level.
    // It samples mosi on rising sclk and drives miso after falling sclk.
    int          s_n = 0;
    logic [31:0] s_bits = '0;
    logic [7:0]  s_op = '0;
    int          s_addr = 0;
    logic        s_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (spi_select !== 1'b0) begin
            s_n      = 0;
            s_op     = '0;
            spi_miso = 1'b0;
        end else if (spi_clk_out === 1'b1 && s_prev_sclk === 1'b0) begin
            s_bits = {s_bits[30:0], spi_mosi};
            s_n++;
            if (s_n == 8) s_op = s_bits[7:0];
            if (s_n == 8 + AB) s_addr = int'(s_bits[AB-1:0]);
            if (s_op == 8'h02 && s_n > 8 + AB && (s_n - 8 - AB) % 8 == 0)
                sram_mem[(s_addr + (s_n - 8 - AB) / 8 - 1) % MEMSZ] = s_bits[7:0];
        end else if (spi_clk_out === 1'b0 && s_prev_sclk === 1'b1) begin
            int hdr;
            hdr = 8 + AB + ((s_op == 8'h0B) ? 8 : 0);
            if ((s_op == 8'h03 || s_op == 8'h0B) && s_n >= hdr) begin
                logic [7:0] byt;
                byt      = sram_mem[(s_addr + (s_n - hdr) / 8) % MEMSZ];
                spi_miso = byt[7 - (s_n - hdr) % 8];
            end else begin
                spi_miso = 1'b0;
            end
        end
        s_prev_sclk = spi_clk_out;
    end

    // The monitor collects each busy window and compares it against the front of the scoreboard.
    initial begin : monitor
        int            busy_cnt, sel_win, sel_run, last_gap, dchg, ncap;
        logic [127:0]  cap;
        logic          prev_busy, prev_sel, prev_sclk;
        logic [DW-1:0] dout_start;
        exp_t          e;
        busy_cnt = 0; sel_win = 0; sel_run = 0; last_gap = -1; dchg = 0; ncap = 0;
        cap = '0; prev_busy = 1'b0; prev_sel = 1'b1; prev_sclk = 1'b0; dout_start = '0;
        @(posedge rst_n);
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (prev_busy !== 1'b1) begin
                    dout_start = data_out;
                    dchg = 0;
                end
                busy_cnt++;
                if (spi_select === 1'b0 && data_out !== dout_start) dchg++;
            end
            if (spi_select === 1'b0 && prev_sel === 1'b1) begin
                sel_win++;
                last_gap = sel_run;
            end
            sel_run = (spi_select === 1'b1) ? sel_run + 1 : 0;
            if (spi_select === 1'b0 && spi_clk_out === 1'b1 && prev_sclk === 1'b0) begin
                cap = {cap[126:0], spi_mosi};
                ncap++;
            end
            if (prev_busy === 1'b1 && busy === 1'b0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_txn: busy fell with no request outstanding, expected none");
                end else begin
                    e = sb.pop_front();
                    if (e.is_abort) begin
                        check("abort_sel", spi_select, 1);
                        check("abort_dout", data_out, 0);
                    end else begin
                        check("busy_len", busy_cnt, e.busy_len);
                        check("mosi_nbits", ncap, e.nbits);
                        check("mosi_stream", cap, e.stream);
                        check("data_out", data_out, e.dout);
                        check("sel_windows", sel_win, 1);
                        check("dout_stable", dchg, 0);
                        if (e.exp_gap >= 0) check("sel_gap", last_gap, e.exp_gap);
                    end
                end
                busy_cnt = 0;
                sel_win  = 0;
                cap      = '0;
                ncap     = 0;
            end
            prev_busy = busy;
            prev_sel  = spi_select;
            prev_sclk = spi_clk_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0) begin
            tick();
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
                return;
            end
        end
    endtask

    // This task builds the expected mosi byte stream and result from the protocol rules.
    // It queues the expectation and then pulses the start inputs for one cycle.
    task automatic issue(input bit wr, input bit rd, input logic [AB-1:0] a,
                         input logic [DW-1:0] d, input int gap_exp, input bit abort_it);
        exp_t          e;
        logic [127:0]  s;
        logic [DW-1:0] rdw;
        logic [7:0]    b;
        int            n, idx;
        s = '0; n = 0; rdw = '0;
        b = wr ? 8'h02 : OP_RD;
        s = {s[119:0], b}; n += 8;
        for (int i = AB / 8 - 1; i >= 0; i--) begin
            s = {s[119:0], a[8*i +: 8]}; n += 8;
        end
        if (!wr) begin
            for (int i = 0; i < RD_EXTRA / 8; i++) begin
                s = {s[119:0], 8'h00}; n += 8;
            end
        end
        for (int i = 0; i < DWB; i++) begin
            idx = (int'(a) + i) % MEMSZ;
            b = wr ? d[8*i +: 8] : 8'h00;
            s = {s[119:0], b}; n += 8;
            if (wr) ref_mem[idx] = d[8*i +: 8];
            else    rdw[8*i +: 8] = ref_mem[idx];
        end
        if (abort_it) last_read = '0;
        else if (!wr) last_read = rdw;
        e.nbits = n; e.stream = s; e.dout = last_read; e.busy_len = 2 * n + 1;
        e.is_abort = abort_it; e.exp_gap = gap_exp;
        sb.push_back(e);
        start_write = wr; start_read = rd; addr_in = a; data_in = d;
        tick();
        start_write = 1'b0; start_read = 1'b0;
        addr_in = AB'($urandom); data_in = DW'($urandom);
    endtask

    // The select-high gap is END plus any idle cycles, so it is 2 + g when the request follows a completion.
    task automatic run(input bit wr, input bit rd, input logic [AB-1:0] a,
                       input logic [DW-1:0] d, input int g);
        wait_idle();
        repeat (g) tick();
        issue(wr, rd, a, d, gap_known ? 2 + g : -1, 1'b0);
        gap_known = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0]    rb;
        logic [AB-1:0] ra;
        for (int i = 0; i < MEMSZ; i++) begin
            rb = 8'($urandom);
            ref_mem[i]  = rb;
            sram_mem[i] = rb;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sel", spi_select, 1);
        check("rst_sclk", spi_clk_out, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_dout", data_out, 0);
        rst_n = 1'b1;
        tick();

        // The directed write should put 02 00 AB 34 12 on mosi, and data_out should stay 0.
        run(1'b1, 1'b0, 16'h00AB, 16'h1234, 0);

        // The directed read has the SRAM return CD then EF.
        ref_mem[16'h1F00] = 8'hCD; sram_mem[16'h1F00] = 8'hCD;
        ref_mem[16'h1F01] = 8'hEF; sram_mem[16'h1F01] = 8'hEF;
        run(1'b0, 1'b1, 16'h1F00, 16'h0000, 0);

        // When both starts are high, the write wins; the read-back confirms what was stored.
        run(1'b1, 1'b1, 16'h0300, 16'hBEEF, 1);
        run(1'b0, 1'b1, 16'h0300, 16'h0000, 0);

        // A start_read pulsed mid-transaction must be neither executed nor queued.
        run(1'b1, 1'b0, 16'h0400, 16'h5A5A, 2);
        repeat (20) tick();
        start_read = 1'b1; addr_in = 16'h0400;
        tick();
        start_read = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            check("no_queued_start", busy, 0);
            tick();
        end
        gap_known = 1'b0;
        run(1'b0, 1'b1, 16'h0400, 16'h0000, 0);

        // Reset is asserted in cycle 30 of a read.
        wait_idle();
        issue(1'b0, 1'b1, 16'h0400, 16'h0000, -1, 1'b1);
        repeat (29) tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy_now", busy, 0);
        check("abort_sel_now", spi_select, 1);
        check("abort_dout_now", data_out, 0);
        check("abort_sclk_now", spi_clk_out, 0);
        rst_n = 1'b1;
        gap_known = 1'b0;
        tick();
        run(1'b0, 1'b1, 16'h1F00, 16'h0000, 0);

        // Back-to-back reads are issued in the first idle cycle, which gives a select gap of END + 1 idle cycle.
        run(1'b0, 1'b1, 16'h0300, 16'h0000, 0);
        run(1'b0, 1'b1, 16'h1F00, 16'h0000, 0);

        // Random mix: a small address window so reads hit earlier writes, plus the wrap at the top.
        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            ra = ($urandom_range(0, 7) == 0) ? AB'(MEMSZ - 1) : AB'(16'h0100 + $urandom_range(0, 31));
            run(kind != 1, kind != 0, ra, DW'($urandom), $urandom_range(0, 3));
        end

        wait_idle();
        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
